// File: rtl/sar_seq_if.sv
// sar_seq_if: the control/data bundle between the SAR sequencer and the
// analog front end it drives.
//   start, cont, chan_en, cmp     : requests and comparator, driven toward the sequencer
//   sh, ch_sel, dac               : analog control outputs (S/H switch, mux select, DAC code)
//   busy, result, result_ch,
//   result_valid                  : status and the tagged result strobe
// Modports: master = the side that drives the requests; slave = the sequencer.
interface sar_seq_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic             start;
    logic             cont;
    logic [NCH-1:0]   chan_en;
    logic             cmp;
    logic             sh;
    logic [CHW-1:0]   ch_sel;
    logic [WIDTH-1:0] dac;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic [CHW-1:0]   result_ch;
    logic             result_valid;

    modport master (
        output start, cont, chan_en, cmp,
        input  sh, ch_sel, dac, busy, result, result_ch, result_valid
    );

    modport slave (
        input  start, cont, chan_en, cmp,
        output sh, ch_sel, dac, busy, result, result_ch, result_valid
    );
endinterface

// File: rtl/sar_seq.sv
// sar_seq: multi-channel SAR conversion sequencer.
// Samples the selected channel for SAMPLE_CYCLES, then resolves WIDTH bits
// MSB-first by binary search, holding each trial code SETTLE_CYCLES+1 cycles.
// Channels are picked round-robin from chan_en; cont keeps scanning.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sar_seq_if slave (start/cont/chan_en/cmp in; sh/ch_sel/dac/
//              busy/result/result_ch/result_valid out, all registered)
module sar_seq #(
    parameter int WIDTH         = 8,
    parameter int NCH           = 4,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic     clk,
    input  logic     rst,
    sar_seq_if.slave bus
);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BW   = $clog2(WIDTH);
    localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

    state_t           state_q, state_d;
    logic [CHW-1:0]   ptr_q, ptr_d;
    logic [CHW-1:0]   ch_sel_q, ch_sel_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sh_q, sh_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CHW-1:0]   result_ch_q, result_ch_d;
    logic             result_valid_q, result_valid_d;

    logic [WIDTH-1:0] kept;      // trial code after resolving the current bit
    logic [CHW-1:0]   next_ptr;  // round-robin pointer after the current channel

    // First enabled channel at or after p, searching upward with wrap.
    function automatic logic [CHW-1:0] pick(input logic [NCH-1:0] en, input logic [CHW-1:0] p);
        logic [CHW-1:0] sel;
        logic           found;
        int             idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(p) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && en[idx]) begin
                sel   = CHW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        ch_sel_d       = ch_sel_q;
        dac_d          = dac_q;
        bit_d          = bit_q;
        cnt_d          = cnt_q;
        sh_d           = sh_q;
        busy_d         = busy_q;
        result_d       = result_q;
        result_ch_d    = result_ch_q;
        result_valid_d = 1'b0;
        kept           = bus.cmp ? dac_q : (dac_q & ~(ONE << bit_q));
        next_ptr       = (ch_sel_q == CHW'(NCH - 1)) ? '0 : CHW'(ch_sel_q + 1'b1);

        case (state_q)
            IDLE: begin
                sh_d   = 1'b0;
                dac_d  = '0;
                busy_d = 1'b0;
                // An empty mask drops the request rather than queueing it.
                if ((bus.start || bus.cont) && (|bus.chan_en)) begin
                    state_d  = SAMPLE;
                    ch_sel_d = pick(bus.chan_en, ptr_q);
                    sh_d     = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = CW'(SAMPLE_CYCLES - 1);
                end
            end
            SAMPLE: begin
                if (cnt_q == '0) begin
                    state_d = CONV;
                    sh_d    = 1'b0;
                    bit_d   = BW'(WIDTH - 1);
                    dac_d   = ONE << (WIDTH - 1);
                    cnt_d   = CW'(SETTLE_CYCLES);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CONV: begin
                // cmp is only trusted on the last edge of the settle window.
                if (cnt_q == '0) begin
                    if (bit_q == '0) begin
                        state_d        = DONE;
                        dac_d          = kept;
                        result_d       = kept;
                        result_ch_d    = ch_sel_q;
                        result_valid_d = 1'b1;
                    end else begin
                        bit_d = bit_q - 1'b1;
                        dac_d = kept | (ONE << (bit_q - 1'b1));
                        cnt_d = CW'(SETTLE_CYCLES);
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                ptr_d = next_ptr;
                dac_d = '0;
                if (bus.cont && (|bus.chan_en)) begin
                    // Back-to-back: no idle cycle between conversions.
                    state_d  = SAMPLE;
                    ch_sel_d = pick(bus.chan_en, next_ptr);
                    sh_d     = 1'b1;
                    cnt_d    = CW'(SAMPLE_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                    sh_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            ch_sel_q       <= '0;
            dac_q          <= '0;
            bit_q          <= '0;
            cnt_q          <= '0;
            sh_q           <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_ch_q    <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            ch_sel_q       <= ch_sel_d;
            dac_q          <= dac_d;
            bit_q          <= bit_d;
            cnt_q          <= cnt_d;
            sh_q           <= sh_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_ch_q    <= result_ch_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.sh           = sh_q;
    assign bus.ch_sel       = ch_sel_q;
    assign bus.dac          = dac_q;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_ch    = result_ch_q;
    assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_sar_seq.sv
// tb_sar_seq: scoreboard bench for sar_seq. Two instances: defaults (A) and
// WIDTH=10/NCH=3/SAMPLE=4/SETTLE=2 (B). Stimulus pushes expected results;
// per-instance monitors pop and compare on every result_valid.
module tb_sar_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sar_seq_if #(.WIDTH(8),  .NCH(4)) ifa ();
    sar_seq_if #(.WIDTH(10), .NCH(3)) ifb ();

    sar_seq #(.WIDTH(8), .NCH(4), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    sar_seq #(.WIDTH(10), .NCH(3), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Comparator: Vin sits half an LSB above its code, so a trial equal to
    // the code still reads "input above DAC" and the search lands on the code.
    logic [1:0] mode_a = 2'd0;  // 0 = model, 1 = tied 1, 2 = tied 0
    logic [7:0] vin_a [4];
    logic [9:0] vin_b [4];
    assign ifa.cmp = (mode_a == 2'd1) ? 1'b1 :
                     (mode_a == 2'd2) ? 1'b0 : (vin_a[ifa.ch_sel] >= ifa.dac);
    assign ifb.cmp = vin_b[ifb.ch_sel] >= ifb.dac;

    typedef struct {int code; int ch; int lat;} exp_t;
    exp_t qa[$];
    exp_t qb[$];
    int   trials_a[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   res_a  = 0;
    int   res_b  = 0;
    int   cyc_a  = 0;
    int   cyc_b  = 0;
    logic [7:0] prev_dac_a = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor A: results, latency (busy cycles incl. DONE) and trial codes.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cyc_a = 0;
        end else begin
            if (ifa.busy) cyc_a++;
            if (ifa.busy && !ifa.sh && !ifa.result_valid && ifa.dac !== prev_dac_a
                && trials_a.size() > 0)
                check("trial_a", ifa.dac, trials_a.pop_front());
            prev_dac_a = ifa.dac;
            if (ifa.result_valid) begin
                res_a++;
                if (qa.size() == 0) check("unexpected_result_a", ifa.result_valid, 0);
                else begin
                    e = qa.pop_front();
                    check("result_a", ifa.result, e.code);
                    check("result_ch_a", ifa.result_ch, e.ch);
                    check("latency_a", cyc_a, e.lat);
                end
                cyc_a = 0;
            end
            if (!ifa.busy) cyc_a = 0;
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cyc_b = 0;
        end else begin
            if (ifb.busy) cyc_b++;
            if (ifb.result_valid) begin
                res_b++;
                if (qb.size() == 0) check("unexpected_result_b", ifb.result_valid, 0);
                else begin
                    e = qb.pop_front();
                    check("result_b", ifb.result, e.code);
                    check("result_ch_b", ifb.result_ch, e.ch);
                    check("latency_b", cyc_b, e.lat);
                end
                cyc_b = 0;
            end
            if (!ifb.busy) cyc_b = 0;
        end
    end

    task automatic pulse(input bit which);
        @(negedge clk);
        if (which) ifb.start = 1'b1; else ifa.start = 1'b1;
        @(negedge clk);
        if (which) ifb.start = 1'b0; else ifa.start = 1'b0;
    endtask

    task automatic wait_idle(input bit which, input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!(which ? ifb.busy : ifa.busy)) return;
        end
        check(name, which ? ifb.busy : ifa.busy, 0);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_sh"},           ifa.sh, 0);
        check({tag, "_ch_sel"},       ifa.ch_sel, 0);
        check({tag, "_dac"},          ifa.dac, 0);
        check({tag, "_busy"},         ifa.busy, 0);
        check({tag, "_result"},       ifa.result, 0);
        check({tag, "_result_ch"},    ifa.result_ch, 0);
        check({tag, "_result_valid"}, ifa.result_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gaps;
        bit started;
        logic busy_hi;
        ifa.start = 0; ifa.cont = 0; ifa.chan_en = '0;
        ifb.start = 0; ifb.cont = 0; ifb.chan_en = '0;
        for (int i = 0; i < 4; i++) begin vin_a[i] = '0; vin_b[i] = '0; end

        repeat (3) @(negedge clk);
        check_reset_a("reset");
        check("reset_busy_b", ifb.busy, 0);
        rst = 1'b0;

        // One-shot 0xA5 on channel 0 with the full trial sequence.
        ifa.chan_en = 4'b0001;
        vin_a[0] = 8'hA5;
        trials_a = {'h80, 'hC0, 'hA0, 'hB0, 'hA8, 'hA4, 'hA6, 'hA5};
        qa.push_back('{'hA5, 0, 19});
        pulse(0);
        wait_idle(0, "t1_timeout", 40);
        check("t1_hold_result", ifa.result, 8'hA5);
        check("t1_idle_dac", ifa.dac, 0);
        check("t1_idle_sh", ifa.sh, 0);

        // Boundary codes.
        mode_a = 2'd1; qa.push_back('{'hFF, 0, 19}); pulse(0); wait_idle(0, "t2_timeout", 40);
        mode_a = 2'd2; qa.push_back('{'h00, 0, 19}); pulse(0); wait_idle(0, "t3_timeout", 40);
        mode_a = 2'd0;

        // Continuous round-robin over channels 1 and 3, then mask cleared mid-conversion.
        vin_a[1] = 8'h12; vin_a[3] = 8'h34;
        ifa.chan_en = 4'b1010;
        qa.push_back('{'h12, 1, 19}); qa.push_back('{'h34, 3, 19});
        qa.push_back('{'h12, 1, 19}); qa.push_back('{'h34, 3, 19});
        qa.push_back('{'h12, 1, 19});
        base = res_a; gaps = 0; started = 0;
        ifa.cont = 1'b1;
        for (int i = 0; i < 200 && res_a < base + 4; i++) begin
            @(negedge clk);
            if (ifa.busy) started = 1;
            else if (started) gaps++;
        end
        repeat (3) @(negedge clk);
        ifa.chan_en = '0;
        wait_idle(0, "t4_timeout", 40);
        check("cont_idle_gaps", gaps, 0);
        check("cont_result_count", res_a - base, 5);
        repeat (3) @(negedge clk);
        check("cont_stays_idle", ifa.busy, 0);
        ifa.cont = 1'b0;

        // Start with an empty mask is dropped.
        busy_hi = 0;
        pulse(0);
        repeat (6) begin @(negedge clk); busy_hi |= ifa.busy; end
        check("empty_mask_busy", busy_hi, 0);

        // Start during CONV is ignored.
        ifa.chan_en = 4'b0001; vin_a[0] = 8'h5A;
        qa.push_back('{'h5A, 0, 19});
        base = res_a;
        pulse(0);
        repeat (8) @(negedge clk);
        pulse(0);
        wait_idle(0, "t6_timeout", 40);
        repeat (25) @(negedge clk);
        check("start_in_conv_count", res_a - base, 1);

        // Reset during bit 4: 0x3C rejects 0x80, 0x40, keeps 0x20 -> trial 0x30.
        vin_a[0] = 8'h3C;
        pulse(0);
        repeat (8) @(negedge clk);
        check("bit4_trial_dac", ifa.dac, 8'h30);
        rst = 1'b1;
        #1;
        check_reset_a("abort");
        @(negedge clk);
        rst = 1'b0;
        qa.push_back('{'h3C, 0, 19});
        pulse(0);
        wait_idle(0, "t7_timeout", 40);

        // Wide config: channel 2 then wrap to channel 0.
        ifb.chan_en = 3'b100; vin_b[2] = 10'h2F3;
        qb.push_back('{'h2F3, 2, 35});
        pulse(1);
        wait_idle(1, "b1_timeout", 80);
        ifb.chan_en = 3'b001; vin_b[0] = 10'h10A;
        qb.push_back('{'h10A, 0, 35});
        pulse(1);
        wait_idle(1, "b2_timeout", 80);
        check("b_ch_sel_wrap", ifb.ch_sel, 0);

        repeat (3) @(negedge clk);
        check("missing_results_a", qa.size(), 0);
        check("missing_results_b", qb.size(), 0);
        check("missing_trials_a", trials_a.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
